// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants: instruction width, NOP encoding,
// fetch FSM state encoding and the sequential PC step.
package mips_pkg;
   localparam int               INSTR_W   = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam int               PC_INC    = 4;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc4} parking slot for a word that returned while ID was stalled.
module fetch_skid_buf
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               drop,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [ADDR_W-1:0]  pc4_in,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc4
);
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc4   <= '0;
      end else if (drop) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc4   <= pc4_in;
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS IF stage: owns PC, one outstanding imem fetch, IF/ID register with skid buffer.
// BRANCH_DELAY_SLOT_EN: keep the word at the current pc and apply redirects after it.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               id_stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc4
);
   fetch_state_e       state, state_d;
   logic               kill, kill_d;
   logic [ADDR_W-1:0]  pc, pc_d, pc_inc, redir_pc;
   logic               rdata_ok, direct_load, park, skid_release, advance, squash;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [ADDR_W-1:0]  skid_pc4;
   logic               unused_bits;

   assign unused_bits = ^redirect_target[1:0];
   assign pc_inc      = pc + ADDR_W'(PC_INC);
   assign redir_pc    = {redirect_target[ADDR_W-1:2], 2'b00};
   assign imem_req    = (state == REQ);
   assign imem_addr   = pc;

   assign rdata_ok     = (state == WAIT) && imem_rvalid && !kill;
   assign direct_load  = rdata_ok && (!if_id_valid || !id_stall);
   assign park         = rdata_ok && if_id_valid && id_stall;
   assign skid_release = (state == HOLD) && !id_stall;
   // The word at pc has been handed to IF/ID this cycle, so pc may move on.
   assign advance      = direct_load || skid_release;

`ifdef BRANCH_DELAY_SLOT_EN
   logic              pend_valid, pend_d;
   logic [ADDR_W-1:0] pend_target, pend_tgt_d;
   assign squash = 1'b0;
`else
   assign squash = redirect_valid;
`endif

   always_comb begin
      state_d = state;
      kill_d  = kill;
      pc_d    = pc;
      case (state)
         IDLE: state_d = REQ;
         REQ:  if (imem_gnt) state_d = WAIT;
         WAIT: if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = park ? HOLD : REQ;
         end
         HOLD: if (!id_stall) state_d = REQ;
         default: state_d = IDLE;
      endcase
      if (advance) pc_d = pc_inc;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_d     = pend_valid;
      pend_tgt_d = pend_target;
      if (advance) begin
         pc_d   = redirect_valid ? redir_pc : (pend_valid ? pend_target : pc_inc);
         pend_d = 1'b0;
      end else if (redirect_valid) begin
         pend_d     = 1'b1;
         pend_tgt_d = redir_pc;
      end
`else
      if (redirect_valid) begin
         pc_d = redir_pc;
         case (state)
            REQ:  if (imem_gnt) kill_d = 1'b1;
            // Data arriving with the redirect is dropped; nothing left in flight.
            WAIT: begin
               kill_d  = !imem_rvalid;
               state_d = imem_rvalid ? REQ : WAIT;
            end
            HOLD: state_d = REQ;
            default: ;
         endcase
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         kill        <= 1'b0;
         pc          <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
      end else begin
         state <= state_d;
         kill  <= kill_d;
         pc    <= pc_d;
         if (squash) begin
            if_id_valid <= 1'b0;
         end else if (direct_load) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_inc;
         end else if (skid_release) begin
            if_id_valid <= 1'b1;
            if_id_instr <= skid_instr;
            if_id_pc4   <= skid_pc4;
         end else if (!id_stall) begin
            if_id_valid <= 1'b0;
         end
      end
   end

`ifdef BRANCH_DELAY_SLOT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else begin
         pend_valid  <= pend_d;
         pend_target <= pend_tgt_d;
      end
   end
`endif

   fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (park && !squash),
      .drop     (skid_release || squash),
      .instr_in (imem_rdata),
      .pc4_in   (pc_inc),
      .valid    (skid_valid),
      .instr    (skid_instr),
      .pc4      (skid_pc4)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: imem responder, scoreboard of delivered words.
module tb_instr_fetch_unit;
   import mips_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        id_stall, redirect_valid;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr, if_id_pc4;

   logic        gnt_en;
   int          lat;
   int          cnt;
   logic        pend;
   logic [31:0] paddr;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .id_stall        (id_stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_id_valid     (if_id_valid),
      .if_id_instr     (if_id_instr),
      .if_id_pc4       (if_id_pc4)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h2008_0005;
         32'h4:   return 32'h0109_5020;
         default: return {16'h2400, a[15:0]};
      endcase
   endfunction

   assign imem_gnt = imem_req & gnt_en;

   // Instruction memory: data returns lat cycles after the grant cycle.
   always @(posedge clk) begin
      imem_rvalid <= 1'b0;
      if (rst) begin
         pend <= 1'b0;
      end else begin
         if (pend) begin
            if (cnt == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem(paddr);
               pend        <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (imem_req && imem_gnt) begin
            if (lat <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem(imem_addr);
            end else begin
               pend  <= 1'b1;
               cnt   <= lat - 1;
               paddr <= imem_addr;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ID consumes IF/ID whenever it is valid and not stalled.
   always @(negedge clk) begin
      if (!rst && if_id_valid && !id_stall) begin
         vectors++;
         assert (sb.size() > 0)
         else begin
            miscompares++;
            $error("FAIL unexpected_word: observed %h expected none", if_id_instr);
         end
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_instr", if_id_instr, e.instr);
            chk("sb_pc4", if_id_pc4, e.pc4);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a);
      exp_t e;
      e.instr = mem(a);
      e.pc4   = a + 32'd4;
      sb.push_back(e);
   endtask

   task automatic chk_req(input string tag, input logic [31:0] addr);
      chk({tag, "_req"}, 32'(imem_req), 32'd1);
      chk({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic wait_req(input string tag, input logic [31:0] addr);
      int n = 0;
      step();
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      chk_req(tag, addr);
   endtask

   initial begin
      rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      gnt_en = 1'b1; lat = 1;
      step(); step();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_pc4", if_id_pc4, 32'h0);
      rst = 1'b0;

      // Sequential fetch, then a 3-cycle ID stall that parks the next word
      push(32'h0);
      wait_req("fetch0", 32'h0);
      wait_req("fetch4", 32'h4);
      chk("w0_valid", 32'(if_id_valid), 32'd1);
      chk("w0_instr", if_id_instr, 32'h2008_0005);
      chk("w0_pc4", if_id_pc4, 32'h4);
      id_stall = 1'b1;
      push(32'h4);
      step(); step();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_valid", 32'(if_id_valid), 32'd1);
      chk("hold_instr", if_id_instr, 32'h2008_0005);
      step();
      id_stall = 1'b0;
      wait_req("release", 32'h8);
      chk("w1_instr", if_id_instr, 32'h0109_5020);
      chk("w1_pc4", if_id_pc4, 32'h8);

      // Redirect while the 0x8 word is returning
      step();
      redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
`ifdef BRANCH_DELAY_SLOT_EN
      push(32'h8);
`endif
      step();
      redirect_valid = 1'b0;
      chk_req("redir40", 32'h40);
`ifdef BRANCH_DELAY_SLOT_EN
      chk("redir40_valid", 32'(if_id_valid), 32'd1);
`else
      chk("redir40_valid", 32'(if_id_valid), 32'd0);
`endif

      // Misaligned target while a 2-cycle fetch is in flight
      lat = 2;
      step();
      redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
`ifdef BRANCH_DELAY_SLOT_EN
      push(32'h40);
`endif
      step();
      redirect_valid = 1'b0;
      wait_req("redir43", 32'h40);
`ifdef BRANCH_DELAY_SLOT_EN
      chk("redir43_valid", 32'(if_id_valid), 32'd1);
`else
      chk("redir43_valid", 32'(if_id_valid), 32'd0);
`endif

      // Redirect coincident with grant, target at the top of the address space
      lat = 1;
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
`ifdef BRANCH_DELAY_SLOT_EN
      push(32'h40);
`endif
      step();
      redirect_valid = 1'b0;
      wait_req("redir_top", 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC);
      wait_req("wrap", 32'h0);
      chk("wrap_valid", 32'(if_id_valid), 32'd1);
      chk("wrap_pc4", if_id_pc4, 32'h0);

      // Redirect while a word sits in the skid buffer
      step();
      id_stall = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
      push(32'h0);
      push(32'h4);
`endif
      wait_req("pre_hold", 32'h4);
      chk("pre_hold_instr", if_id_instr, 32'h2008_0005);
      step(); step();
      chk("hold2_req", 32'(imem_req), 32'd0);
      redirect_valid = 1'b1; redirect_target = 32'h0000_0080;
      step();
      redirect_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      chk("hold_redir_req", 32'(imem_req), 32'd0);
      id_stall = 1'b0;
      wait_req("hold_redir", 32'h80);
`else
      chk("hold_redir_valid", 32'(if_id_valid), 32'd0);
      chk_req("hold_redir", 32'h80);
      id_stall = 1'b0;
`endif
      gnt_en = 1'b0;
      repeat (4) step();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
